inv_cipher: RTL and testbench

Iterative AES inverse cipher (FIPS-197 InvCipher) that decrypts one 128-bit block per transaction, one round per clock. It is the receive-side counterpart of the encryption core and consumes the same expanded key schedule bus, unmodified. Key size is selected by parameter x (AES-128/192/256). It sits after the key-expansion block and beside the encryption core in the top-level datapath.

---
 rtl/inv_cipher_if.sv | 18 +
 rtl/inv_cipher.sv | 182 ++++++++++++++++++
 tb/tb_inv_cipher.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_cipher_if.sv
// rtl/inv_cipher_if.sv - request/response bundle for the inverse cipher
// Purpose: groups the block handshake of inv_cipher into one port.
// Signals:
//   start  request to decrypt `in` (taken only while the core is idle)
//   in     128-bit ciphertext, byte 0 in bits [127:120]
//   out    128-bit plaintext, valid when done=1 and held until the next result
//   busy   high while a block is in progress
//   done   one-cycle strobe marking a new value on out
interface inv_cipher_if;
  logic         start;
  logic [127:0] in;
  logic [127:0] out;
  logic         busy;
  logic         done;

  modport master (output start, output in, input out, input busy, input done);
  modport slave  (input start, input in, output out, output busy, output done);
endinterface

// File: rtl/inv_cipher.sv
// rtl/inv_cipher.sv - iterative AES inverse cipher, one round per clock
// Purpose: decrypts one 128-bit block per request using a precomputed key
//          schedule; key size selected by x (0/1/2 -> AES-128/192/256).
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst    synchronous active-high reset, aborts any block in flight
//   words  expanded key schedule, round key i = words[128*i +: 128]
//   bus    slave side of inv_cipher_if (start/in request, out/busy/done result)
// Byte k of a block sits in bits [127-8k -: 8]; the state is column-major,
// so byte k is row k%4, column k/4.
module inv_cipher #(
  parameter int x = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [128*(11+2*x)-1:0] words,
  inv_cipher_if.slave             bus
);

  localparam int         NR        = 10 + 2 * x;
  localparam logic [3:0] RND_FIRST = 4'(NR - 1);

  typedef enum logic {IDLE, ROUND} state_t;

  state_t       state, state_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [127:0] state_reg, state_reg_nxt;
  logic [127:0] out_r, out_nxt;
  logic         busy_r, busy_nxt;
  logic         done_r, done_nxt;
  logic [127:0] round_key;
  logic [127:0] round_core;

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map (rotations 1, 3, 6 and constant 0x05),
  // then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // ---------------------------------------------------------------- round helpers
  function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                 input logic [127:0] k);
    return s ^ k;
  endfunction

  // Row r is rotated right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------- datapath
  // Round key select by rnd; unused codes above NR fall back to key 0.
  always_comb begin
    round_key = words[127:0];
    for (int i = 1; i <= NR; i++) begin
      if (rnd == 4'(i)) round_key = words[128*i +: 128];
    end
  end

  // Shared by the middle rounds (followed by InvMixColumns) and the last round.
  assign round_core = add_round_key(inv_sub_bytes(inv_shift_rows(state_reg)), round_key);

  // ---------------------------------------------------------------- control
  always_comb begin
    state_nxt     = state;
    rnd_nxt       = rnd;
    state_reg_nxt = state_reg;
    out_nxt       = out_r;
    busy_nxt      = busy_r;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_reg_nxt = add_round_key(bus.in, words[128*NR +: 128]);
          rnd_nxt       = RND_FIRST;
          busy_nxt      = 1'b1;
          state_nxt     = ROUND;
        end
      end
      ROUND: begin
        if (rnd != 4'd0) begin
          state_reg_nxt = inv_mix_columns(round_core);
          rnd_nxt       = rnd - 4'd1;
        end else begin
          out_nxt   = round_core;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= 4'd0;
      state_reg <= '0;
      out_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      rnd       <= rnd_nxt;
      state_reg <= state_reg_nxt;
      out_r     <= out_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
    end
  end

  assign bus.out  = out_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_inv_cipher.sv
// tb/tb_inv_cipher.sv - self-checking bench for inv_cipher (x = 0, 1, 2)
module tb_inv_cipher;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_cipher_if if0 ();
  inv_cipher_if if1 ();
  inv_cipher_if if2 ();

  logic [128*11-1:0] words0;
  logic [128*13-1:0] words1;
  logic [128*15-1:0] words2;

  inv_cipher #(.x(0)) dut0 (.clk(clk), .rst(rst), .words(words0), .bus(if0));
  inv_cipher #(.x(1)) dut1 (.clk(clk), .rst(rst), .words(words1), .bus(if1));
  inv_cipher #(.x(2)) dut2 (.clk(clk), .rst(rst), .words(words2), .bus(if2));

  int total;
  int bad;

  // Forward S-box, row-major 00..ff.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sb(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // Key expansion; key is left-aligned in 256 bits, round key r at [128*r +: 128].
  function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
    logic [31:0]   w [0:59];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] res;
    int            nr;
    nr  = nk + 6;
    res = '0;
    rc  = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) res[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  // Forward cipher used to produce ciphertexts for the loopback check.
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] ex,
                                           input int nr);
    logic [127:0] s;
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ ex[127:0];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) t[127-8*k -: 8] = sb(s[127-8*k -: 8]);
      for (int c = 0; c < 4; c++)
        for (int r2 = 0; r2 < 4; r2++)
          s[127-8*(r2+4*c) -: 8] = t[127-8*(r2+4*((c+r2)%4)) -: 8];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = s ^ ex[128*r +: 128];
    end
    return s;
  endfunction

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic st, input logic [127:0] d);
    case (s)
      0: begin if0.start = st; if0.in = d; end
      1: begin if1.start = st; if1.in = d; end
      default: begin if2.start = st; if2.in = d; end
    endcase
  endtask

  function automatic logic rd_done(input int s);
    case (s)
      0: return if0.done;
      1: return if1.done;
      default: return if2.done;
    endcase
  endfunction

  function automatic logic rd_busy(input int s);
    case (s)
      0: return if0.busy;
      1: return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic [127:0] rd_out(input int s);
    case (s)
      0: return if0.out;
      1: return if1.out;
      default: return if2.out;
    endcase
  endfunction

  task automatic set_words(input int s, input logic [255:0] key);
    logic [1919:0] ex;
    ex = expand(4 + 2 * s, key);
    case (s)
      0: words0 = ex[128*11-1:0];
      1: words1 = ex[128*13-1:0];
      default: words2 = ex;
    endcase
  endtask

  // One start pulse; checks latency Nr+1, busy length Nr, result and done width.
  task automatic run_block(input int s, input logic [127:0] ct, input logic [127:0] pt,
                           input string name);
    int edges;
    int busy_cnt;
    drive(s, 1'b1, ct);
    tick();
    drive(s, 1'b0, ct);
    edges    = 1;
    busy_cnt = 0;
    while (rd_done(s) !== 1'b1 && edges < 40) begin
      if (rd_busy(s) === 1'b1) busy_cnt++;
      tick();
      edges++;
    end
    check_int({name, " latency"}, edges, 11 + 2 * s);
    check_int({name, " busy cycles"}, busy_cnt, 10 + 2 * s);
    check128({name, " out"}, rd_out(s), pt);
    check1({name, " busy at done"}, rd_busy(s), 1'b0);
    tick();
    check1({name, " done width"}, rd_done(s), 1'b0);
  endtask

  typedef struct {
    int           sel;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs [4];
    logic [255:0]  key;
    logic [127:0]  ptv;
    logic [127:0]  ctv;
    logic [1919:0] ex;
    int            n;

    total = 0;
    bad   = 0;

    vecs[0] = '{0, KEY_C1, CT_C1, PT_C};
    vecs[1] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_C};
    vecs[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, PT_C};
    vecs[3] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};

    rst = 1'b1;
    words0 = '0;
    words1 = '0;
    words2 = '0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 128'h0);
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      check128($sformatf("reset out %0d", s), rd_out(s), 128'h0);
      check1($sformatf("reset busy %0d", s), rd_busy(s), 1'b0);
      check1($sformatf("reset done %0d", s), rd_done(s), 1'b0);
    end
    rst = 1'b0;
    tick();

    // Known-answer vectors for all three key sizes.
    for (int v = 0; v < 4; v++) begin
      set_words(vecs[v].sel, vecs[v].key);
      run_block(vecs[v].sel, vecs[v].ct, vecs[v].pt, $sformatf("vec%0d", v));
      tick();
    end

    // start held high: a result every 11 cycles; `in` disturbed only while busy.
    set_words(0, KEY_C1);
    drive(0, 1'b1, CT_C1);
    tick();
    for (int k = 1; k <= 33; k++) begin
      check1($sformatf("held done k=%0d", k), if0.done, (k % 11) == 0);
      check1($sformatf("held busy k=%0d", k), if0.busy, (k % 11) != 0);
      if (k % 11 == 0) check128($sformatf("held out k=%0d", k), if0.out, PT_C);
      if (k == 33) drive(0, 1'b0, CT_C1);
      else if (k % 11 >= 3 && k % 11 <= 7) drive(0, 1'b1, 128'hdeadbeef_01234567_89abcdef_55aa55aa);
      else drive(0, 1'b1, CT_C1);
      tick();
    end
    check1("held stop busy", if0.busy, 1'b0);

    // Reset in the middle of a block.
    drive(0, 1'b1, CT_C1);
    tick();
    drive(0, 1'b0, CT_C1);
    repeat (5) tick();
    check1("abort busy before rst", if0.busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check128("abort out", if0.out, 128'h0);
    check1("abort busy", if0.busy, 1'b0);
    check1("abort done", if0.done, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if0.done !== 1'b0) n++;
    end
    check_int("abort stray done pulses", n, 0);

    // New start after the abort, with `in` overwritten one cycle after start.
    drive(0, 1'b1, CT_C1);
    tick();
    drive(0, 1'b0, CT_C1);
    tick();
    drive(0, 1'b0, {128{1'b1}});
    n = 2;
    while (if0.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_int("in change latency", n, 11);
    check128("in change out", if0.out, PT_C);
    for (int i = 0; i < 20; i++) begin
      tick();
      check1($sformatf("hold done %0d", i), if0.done, 1'b0);
      check128($sformatf("hold out %0d", i), if0.out, PT_C);
    end

    // Loopback against the forward cipher with random keys and blocks.
    for (int it = 0; it < 1000; it++) begin
      key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      ptv = {$urandom, $urandom, $urandom, $urandom};
      ex  = expand(4, key);
      words0 = ex[128*11-1:0];
      ctv = encrypt(ptv, ex, 10);
      drive(0, 1'b1, ctv);
      tick();
      drive(0, 1'b0, ctv);
      n = 1;
      while (if0.done !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      check128($sformatf("loopback %0d", it), if0.out, ptv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
